// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter slice.
//   DATA_LEN / ROB_LEN : default result/PC width and ROB alias width
//   SRC_ALU / SRC_LSB  : encoding of cdb_src and of the last-grant register
//   pick_lsb()         : round-robin grant decision between the two FIFO heads
package cdb_arbiter_pkg;

    localparam int DATA_LEN = 32;
    localparam int ROB_LEN  = 4;

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSB = 1'b1;

    // LSB wins if it is the only pending source, or if both are pending
    // and the ALU was granted last.
    function automatic logic pick_lsb(input logic alu_pending,
                                      input logic lsb_pending,
                                      input logic last_grant);
        return lsb_pending && (!alu_pending || (last_grant == SRC_ALU));
    endfunction

endpackage

// File: rtl/cdb_arbiter_result_fifo.sv
// Small synchronous FIFO holding completed results for one CDB source.
//   clk, rst (async, active-low), rdy (global enable)
//   flush      : empties the FIFO and drops a same-cycle push
//   push/push_data : write request; ignored while full
//   pop        : read request; ignored while empty
//   pop_data   : current head entry
//   empty/full : derived from the occupancy count only
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign do_push  = rdy && !flush && push && !full;
    assign do_pop   = rdy && !flush && pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (rdy) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + (PTR_W+1)'(1);
                    2'b01:   count <= count - (PTR_W+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage carries data only; validity comes from count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Serialises ALU and LSB completions onto one registered common data bus.
//   clk, rst (async, active-low), rdy (global enable), rollback (flush)
//   alu_valid/alias/result/jump/real_pc, alu_full : ALU result input
//   lsb_valid/alias/result, lsb_full              : LSB result input
//   cdb_valid/src/alias/result/jump/real_pc       : registered broadcast
//   overflow_err : sticky, set when a push hits a full FIFO
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DATA_W     = DATA_LEN,
    parameter int ROB_W      = ROB_LEN,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              alu_valid,
    input  logic [ROB_W-1:0]  alu_alias,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_jump,
    input  logic [DATA_W-1:0] alu_real_pc,
    output logic              alu_full,
    input  logic              lsb_valid,
    input  logic [ROB_W-1:0]  lsb_alias,
    input  logic [DATA_W-1:0] lsb_result,
    output logic              lsb_full,
    output logic              cdb_valid,
    output logic              cdb_src,
    output logic [ROB_W-1:0]  cdb_alias,
    output logic [DATA_W-1:0] cdb_result,
    output logic              cdb_jump,
    output logic [DATA_W-1:0] cdb_real_pc,
    output logic              overflow_err
);

    localparam int ALU_PW = ROB_W + DATA_W + 1 + DATA_W;
    localparam int LSB_PW = ROB_W + DATA_W;

    logic              alu_push;
    logic              lsb_push;
    logic              alu_empty;
    logic              lsb_empty;
    logic              alu_pop;
    logic              lsb_pop;
    logic [ALU_PW-1:0] alu_head;
    logic [LSB_PW-1:0] lsb_head;
    logic              last_grant;
    logic              any_pending;
    logic              grant;

    logic [ROB_W-1:0]  alu_h_alias;
    logic [DATA_W-1:0] alu_h_result;
    logic              alu_h_jump;
    logic [DATA_W-1:0] alu_h_pc;
    logic [ROB_W-1:0]  lsb_h_alias;
    logic [DATA_W-1:0] lsb_h_result;

    // Alias 0 means "no dependency" and is never a real destination.
    assign alu_push = alu_valid && (alu_alias != '0);
    assign lsb_push = lsb_valid && (lsb_alias != '0);

    assign any_pending = !alu_empty || !lsb_empty;
    assign grant       = pick_lsb(!alu_empty, !lsb_empty, last_grant);
    assign alu_pop     = any_pending && (grant == SRC_ALU);
    assign lsb_pop     = any_pending && (grant == SRC_LSB);

    result_fifo #(.WIDTH(ALU_PW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (rollback),
        .push      (alu_push),
        .push_data ({alu_alias, alu_result, alu_jump, alu_real_pc}),
        .pop       (alu_pop),
        .pop_data  (alu_head),
        .empty     (alu_empty),
        .full      (alu_full)
    );

    result_fifo #(.WIDTH(LSB_PW), .DEPTH(FIFO_DEPTH)) u_lsb_fifo (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (rollback),
        .push      (lsb_push),
        .push_data ({lsb_alias, lsb_result}),
        .pop       (lsb_pop),
        .pop_data  (lsb_head),
        .empty     (lsb_empty),
        .full      (lsb_full)
    );

    assign {alu_h_alias, alu_h_result, alu_h_jump, alu_h_pc} = alu_head;
    assign {lsb_h_alias, lsb_h_result}                       = lsb_head;

    // A push is counted as an overflow only when it would otherwise have
    // been accepted; rollback already discards same-cycle pushes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err <= 1'b0;
        end else if (rdy && !rollback &&
                     ((alu_push && alu_full) || (lsb_push && lsb_full))) begin
            overflow_err <= 1'b1;
        end
    end

    // CDB output register: FIFO heads -> broadcast, one result per cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid   <= 1'b0;
            cdb_src     <= SRC_ALU;
            cdb_alias   <= '0;
            cdb_result  <= '0;
            cdb_jump    <= 1'b0;
            cdb_real_pc <= '0;
            last_grant  <= SRC_LSB;
        end else if (rdy) begin
            if (rollback || !any_pending) begin
                cdb_valid <= 1'b0;
            end else begin
                cdb_valid  <= 1'b1;
                cdb_src    <= grant;
                last_grant <= grant;
                if (grant == SRC_LSB) begin
                    cdb_alias   <= lsb_h_alias;
                    cdb_result  <= lsb_h_result;
                    cdb_jump    <= 1'b0;
                    cdb_real_pc <= '0;
                end else begin
                    cdb_alias   <= alu_h_alias;
                    cdb_result  <= alu_h_result;
                    cdb_jump    <= alu_h_jump;
                    cdb_real_pc <= alu_h_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        rollback = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_alias = 4'd0;
    logic [31:0] alu_result = 32'd0;
    logic        alu_jump = 1'b0;
    logic [31:0] alu_real_pc = 32'd0;
    logic        alu_full;
    logic        lsb_valid = 1'b0;
    logic [3:0]  lsb_alias = 4'd0;
    logic [31:0] lsb_result = 32'd0;
    logic        lsb_full;
    logic        cdb_valid;
    logic        cdb_src;
    logic [3:0]  cdb_alias;
    logic [31:0] cdb_result;
    logic        cdb_jump;
    logic [31:0] cdb_real_pc;
    logic        overflow_err;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.DATA_W(32), .ROB_W(4), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .alu_valid(alu_valid), .alu_alias(alu_alias), .alu_result(alu_result),
        .alu_jump(alu_jump), .alu_real_pc(alu_real_pc), .alu_full(alu_full),
        .lsb_valid(lsb_valid), .lsb_alias(lsb_alias), .lsb_result(lsb_result),
        .lsb_full(lsb_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_alias(cdb_alias),
        .cdb_result(cdb_result), .cdb_jump(cdb_jump), .cdb_real_pc(cdb_real_pc),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  aa;
        logic [31:0] ar;
        logic        aj;
        logic [31:0] ap;
        logic        lv;
        logic [3:0]  la;
        logic [31:0] lr;
        logic        ev;
        logic        es;
        logic [3:0]  ea;
        logic [31:0] er;
        logic        ej;
        logic [31:0] ep;
        logic        eaf;
        logic        elf;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_alias = 4'd0; alu_result = 32'd0;
        alu_jump = 1'b0; alu_real_pc = 32'd0;
        lsb_valid = 1'b0; lsb_alias = 4'd0; lsb_result = 32'd0;
        rollback = 1'b0;
    endtask

    task automatic alu_in(input logic [3:0] a, input logic [31:0] r,
                          input logic j, input logic [31:0] pc);
        alu_valid = 1'b1; alu_alias = a; alu_result = r; alu_jump = j; alu_real_pc = pc;
    endtask

    task automatic lsb_in(input logic [3:0] a, input logic [31:0] r);
        lsb_valid = 1'b1; lsb_alias = a; lsb_result = r;
    endtask

    task automatic expect_bcast(input string name, input logic src, input logic [3:0] a,
                                input logic [31:0] r);
        check({name, "_valid"}, {31'd0, cdb_valid}, 32'd1);
        check({name, "_src"}, {31'd0, cdb_src}, {31'd0, src});
        check({name, "_alias"}, {28'd0, cdb_alias}, {28'd0, a});
        check({name, "_result"}, cdb_result, r);
    endtask

    task automatic expect_quiet(input string name);
        check({name, "_valid"}, {31'd0, cdb_valid}, 32'd0);
    endtask

    task automatic expect_all_zero(input string name);
        check({name, "_valid"}, {31'd0, cdb_valid}, 32'd0);
        check({name, "_src"}, {31'd0, cdb_src}, 32'd0);
        check({name, "_alias"}, {28'd0, cdb_alias}, 32'd0);
        check({name, "_result"}, cdb_result, 32'd0);
        check({name, "_jump"}, {31'd0, cdb_jump}, 32'd0);
        check({name, "_pc"}, cdb_real_pc, 32'd0);
        check({name, "_alu_full"}, {31'd0, alu_full}, 32'd0);
        check({name, "_lsb_full"}, {31'd0, lsb_full}, 32'd0);
        check({name, "_ovf"}, {31'd0, overflow_err}, 32'd0);
    endtask

    initial begin
        // Table: contention from reset (ALU wins first tie), single ALU result, alias 0.
        tbl[0]  = '{1'b1, 4'd1, 32'h11, 1'b0, 32'h100, 1'b1, 4'd5, 32'h55,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 4'd2, 32'h22, 1'b1, 32'h200, 1'b1, 4'd6, 32'h66,
                    1'b1, 1'b0, 4'd1, 32'h11, 1'b0, 32'h100, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b1, 1'b1, 4'd5, 32'h55, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b1, 1'b0, 4'd2, 32'h22, 1'b1, 32'h200, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b1, 1'b1, 4'd6, 32'h66, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'd3, 32'h1234, 1'b1, 32'h80, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b1, 1'b0, 4'd3, 32'h1234, 1'b1, 32'h80, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b1, 4'd0, 32'hdead,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 4'd0, 32'hbeef, 1'b1, 32'h44, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 4'd0, 32'h0,
                    1'b0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};

        // Power-on reset
        idle();
        #12;
        expect_all_zero("por");
        @(negedge clk);
        rst = 1'b1;
        rdy = 1'b1;

        for (int i = 0; i < 13; i++) begin
            alu_valid = tbl[i].av; alu_alias = tbl[i].aa; alu_result = tbl[i].ar;
            alu_jump = tbl[i].aj; alu_real_pc = tbl[i].ap;
            lsb_valid = tbl[i].lv; lsb_alias = tbl[i].la; lsb_result = tbl[i].lr;
            tick();
            check($sformatf("vec%0d_valid", i), {31'd0, cdb_valid}, {31'd0, tbl[i].ev});
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_src", i), {31'd0, cdb_src}, {31'd0, tbl[i].es});
                check($sformatf("vec%0d_alias", i), {28'd0, cdb_alias}, {28'd0, tbl[i].ea});
                check($sformatf("vec%0d_result", i), cdb_result, tbl[i].er);
                check($sformatf("vec%0d_jump", i), {31'd0, cdb_jump}, {31'd0, tbl[i].ej});
                check($sformatf("vec%0d_pc", i), cdb_real_pc, tbl[i].ep);
            end
            check($sformatf("vec%0d_alu_full", i), {31'd0, alu_full}, {31'd0, tbl[i].eaf});
            check($sformatf("vec%0d_lsb_full", i), {31'd0, lsb_full}, {31'd0, tbl[i].elf});
            check($sformatf("vec%0d_ovf", i), {31'd0, overflow_err}, 32'd0);
        end
        idle();

        // Full / overflow (last grant is ALU here, so the LSB wins the next tie)
        alu_in(4'd1, 32'h101, 1'b0, 32'h0); lsb_in(4'd9, 32'h909);
        tick(); idle();
        expect_quiet("ovf_e1");
        alu_in(4'd2, 32'h102, 1'b0, 32'h0);
        tick(); idle();
        expect_bcast("ovf_e2", 1'b1, 4'd9, 32'h909);
        check("ovf_e2_alu_full", {31'd0, alu_full}, 32'd1);
        check("ovf_e2_ovf", {31'd0, overflow_err}, 32'd0);
        alu_in(4'd4, 32'h104, 1'b0, 32'h0);
        tick(); idle();
        check("ovf_e3_ovf", {31'd0, overflow_err}, 32'd1);
        expect_bcast("ovf_e3", 1'b0, 4'd1, 32'h101);
        check("ovf_e3_alu_full", {31'd0, alu_full}, 32'd0);
        tick();
        expect_bcast("ovf_e4", 1'b0, 4'd2, 32'h102);
        tick();
        expect_quiet("ovf_e5");
        check("ovf_sticky", {31'd0, overflow_err}, 32'd1);

        // Rollback with a same-cycle ALU push
        alu_in(4'd1, 32'h201, 1'b0, 32'h0); lsb_in(4'd5, 32'h205);
        tick(); idle();
        alu_in(4'd2, 32'h202, 1'b0, 32'h0); lsb_in(4'd6, 32'h206);
        tick(); idle();
        expect_bcast("rb_e2", 1'b1, 4'd5, 32'h205);
        lsb_in(4'd8, 32'h208);
        tick(); idle();
        expect_bcast("rb_e3", 1'b0, 4'd1, 32'h201);
        check("rb_e3_lsb_full", {31'd0, lsb_full}, 32'd1);
        rollback = 1'b1; alu_in(4'd7, 32'h207, 1'b0, 32'h0);
        tick(); idle();
        expect_quiet("rb_flush");
        check("rb_alu_full", {31'd0, alu_full}, 32'd0);
        check("rb_lsb_full", {31'd0, lsb_full}, 32'd0);
        check("rb_ovf_kept", {31'd0, overflow_err}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_quiet($sformatf("rb_drain%0d", k));
        end
        // last grant (ALU) survives rollback: the LSB wins this tie
        alu_in(4'd3, 32'h303, 1'b0, 32'h0); lsb_in(4'd4, 32'h404);
        tick(); idle();
        tick();
        expect_bcast("rb_lg1", 1'b1, 4'd4, 32'h404);
        tick();
        expect_bcast("rb_lg2", 1'b0, 4'd3, 32'h303);
        tick();
        expect_quiet("rb_lg3");

        // rdy = 0 freezes everything, including pushes
        alu_in(4'd9, 32'h99, 1'b0, 32'h0);
        tick();
        alu_in(4'd10, 32'haa, 1'b0, 32'h0);
        tick();
        expect_bcast("rdy_pre", 1'b0, 4'd9, 32'h99);
        rdy = 1'b0;
        alu_in(4'd11, 32'hbb, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            expect_bcast($sformatf("rdy_hold%0d", k), 1'b0, 4'd9, 32'h99);
        end
        idle();
        rdy = 1'b1;
        tick();
        expect_bcast("rdy_resume", 1'b0, 4'd10, 32'haa);
        tick();
        expect_quiet("rdy_no_push");

        // Asynchronous reset mid-traffic
        alu_in(4'd1, 32'h501, 1'b1, 32'h5); lsb_in(4'd2, 32'h502);
        tick(); idle();
        tick();
        expect_bcast("ar_pre", 1'b1, 4'd2, 32'h502);
        #2 rst = 1'b0;
        #1;
        expect_all_zero("ar_async");
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_quiet("ar_empty");
        alu_in(4'd3, 32'h603, 1'b0, 32'h0); lsb_in(4'd4, 32'h604);
        tick(); idle();
        tick();
        expect_bcast("ar_tie", 1'b0, 4'd3, 32'h603);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
